// File: rtl/cache_pkg.sv
// Shared types, widths and helpers for the N-way write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT,
    RESPOND
  } state_t;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 11;
  localparam int DEF_BLOCK_SIZE = 16;
  localparam int DEF_CACHE_SIZE = 256;
  localparam int DEF_NUM_WAYS   = 4;
  localparam int DEF_STAT_WIDTH = 16;
  localparam int DEF_NUM_SETS   = DEF_CACHE_SIZE / (DEF_BLOCK_SIZE * DEF_NUM_WAYS);
  localparam int DEF_OFFSET_W   = clog2(DEF_BLOCK_SIZE);
  localparam int DEF_INDEX_W    = clog2(DEF_NUM_SETS);
  localparam int DEF_TAG_W      = DEF_ADDR_WIDTH - DEF_INDEX_W - DEF_OFFSET_W;
  localparam int DEF_AGE_W      = clog2(DEF_NUM_WAYS);

  // Line-aligned address {tag, index, zero offset}; caller truncates to ADDR_WIDTH.
  function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] index,
                                            input int index_w, input int offset_w);
    return ((tag << index_w) | index) << offset_w;
  endfunction

endpackage

// File: rtl/cache_nway_wb_if.sv
// Request/response and backing-memory handshake bundle for cache_nway_wb.
interface cache_nway_wb_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 11
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_hit;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  // Environment side: request generator plus backing memory.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit, mem_req_valid, mem_req_write, mem_req_addr,
           mem_req_wdata
  );

  // Cache side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit, mem_req_valid, mem_req_write, mem_req_addr,
           mem_req_wdata
  );
endinterface

// File: rtl/cache_lru_nway.sv
// True-LRU age tracking per set: victim choice and age update on access.
module cache_lru_nway
  import cache_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  localparam int SET_W = clog2(NUM_SETS),
  localparam int AGE_W = clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_W-1:0]    sel_set,
  input  logic [NUM_WAYS-1:0] sel_valid,
  output logic [AGE_W-1:0]    victim,
  input  logic                upd_en,
  input  logic [AGE_W-1:0]    upd_way
);
  logic [AGE_W-1:0] age_q [NUM_SETS][NUM_WAYS];

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    victim = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (age_q[sel_set][w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!sel_valid[w]) victim = AGE_W'(w);
    end
  end

  // Age update: accessed way becomes youngest, younger ways age by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end
    end else if (upd_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (AGE_W'(w) == upd_way)
          age_q[sel_set][w] <= '0;
        else if (age_q[sel_set][w] < age_q[sel_set][upd_way])
          age_q[sel_set][w] <= age_q[sel_set][w] + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back/write-allocate cache, one word per line.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int CACHE_SIZE = DEF_CACHE_SIZE,
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int STAT_WIDTH = DEF_STAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_nway_wb_if.slave        bus,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
);
  localparam int NUM_SETS = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
  localparam int OFFSET_W = clog2(BLOCK_SIZE);
  localparam int INDEX_W  = clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int AGE_W    = clog2(NUM_WAYS);

  state_t                state;
  logic                  r_write;
  logic [TAG_W-1:0]      r_tag;
  logic [INDEX_W-1:0]    r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [AGE_W-1:0]      victim, victim_q, hit_way;
  logic                  hit, lru_upd, fill_fire, wr_hit;
  logic [DATA_WIDTH-1:0] hit_data, fill_data;
  logic [ADDR_WIDTH-1:0] fill_line, victim_line;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic                  req_ready_q, resp_valid_q, resp_hit_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q, mem_wdata_q;
  logic                  mem_valid_q, mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_hit      = resp_hit_q;
  assign bus.mem_req_valid = mem_valid_q;
  assign bus.mem_req_write = mem_write_q;
  assign bus.mem_req_addr  = mem_addr_q;
  assign bus.mem_req_wdata = mem_wdata_q;

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[r_idx][w] && tag_q[r_idx][w] == r_tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  assign fill_fire   = (state == FILL_WAIT) && bus.mem_resp_valid;
  assign wr_hit      = (state == LOOKUP) && hit && r_write;
  assign lru_upd     = ((state == LOOKUP) && hit) || fill_fire;
  assign hit_data    = r_write ? r_wdata : data_q[r_idx][hit_way];
  assign fill_data   = r_write ? r_wdata : bus.mem_resp_rdata;
  assign fill_line   = ADDR_WIDTH'(line_addr(32'(r_tag), 32'(r_idx), INDEX_W, OFFSET_W));
  assign victim_line = ADDR_WIDTH'(line_addr(32'(tag_q[r_idx][victim]), 32'(r_idx), INDEX_W, OFFSET_W));

  cache_lru_nway #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .sel_set   (r_idx),
    .sel_valid (valid_q[r_idx]),
    .victim    (victim),
    .upd_en    (lru_upd),
    .upd_way   ((state == LOOKUP) ? hit_way : victim_q)
  );

  // Working request is loaded only by the IDLE handshake.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      r_write <= bus.req_write;
      r_tag   <= bus.req_addr[ADDR_WIDTH-1 -: TAG_W];
      r_idx   <= bus.req_addr[OFFSET_W +: INDEX_W];
      r_wdata <= bus.req_wdata;
    end
  end

  // Line storage: write hits update data, fills install tag and data.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      data_q[r_idx][hit_way] <= r_wdata;
    end else if (fill_fire) begin
      data_q[r_idx][victim_q] <= fill_data;
      tag_q[r_idx][victim_q]  <= r_tag;
    end
  end

  // Control FSM: handshakes, valid/dirty bits, statistics and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_hit_q   <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      victim_q     <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (r_write) dirty_q[r_idx][hit_way] <= 1'b1;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_rdata_q <= hit_data;
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
            state <= RESPOND;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            victim_q    <= victim;
            mem_valid_q <= 1'b1;
            if (valid_q[r_idx][victim] && dirty_q[r_idx][victim]) begin
              mem_write_q <= 1'b1;
              mem_addr_q  <= victim_line;
              mem_wdata_q <= data_q[r_idx][victim];
              state       <= WB_REQ;
            end else begin
              mem_write_q <= 1'b0;
              mem_addr_q  <= fill_line;
              state       <= FILL_REQ;
            end
          end
        end
        WB_REQ: begin
          // Writeback must complete before the fill is issued.
          if (bus.mem_req_ready) begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= fill_line;
            state       <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (bus.mem_req_ready) begin
            mem_valid_q <= 1'b0;
            state       <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (bus.mem_resp_valid) begin
            valid_q[r_idx][victim_q] <= 1'b1;
            dirty_q[r_idx][victim_q] <= r_write;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= fill_data;
            state        <= RESPOND;
          end
        end
        RESPOND: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_nway_wb.sv
// Bench for cache_nway_wb: table of transactions, memory model, response scoreboard.
module tb_cache_nway_wb;
  localparam int SW = 8;
  localparam int SMAX = (1 << SW) - 1;

  typedef struct {
    bit         w;
    logic [10:0] a;
    logic [10:0] d;
    logic [10:0] er;
    bit         eh;
    int         nm;
  } vec_t;

  typedef struct {
    logic [10:0] rd;
    bit          hit;
  } exp_t;

  typedef struct {
    bit          w;
    logic [10:0] a;
    logic [10:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [SW-1:0] hit_count, miss_count;

  cache_nway_wb_if #(.ADDR_WIDTH(11), .DATA_WIDTH(11)) bus ();

  // Counters narrowed so that saturation is reachable in a short run.
  cache_nway_wb #(
    .ADDR_WIDTH (11),
    .DATA_WIDTH (11),
    .BLOCK_SIZE (16),
    .CACHE_SIZE (256),
    .NUM_WAYS   (4),
    .STAT_WIDTH (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;
  bit   mem_ready_en = 1'b1;
  exp_t sb[$];
  txn_t mlog[$];
  txn_t elog[$];
  logic [10:0] mem [128];
  vec_t tbl[17];

  function automatic logic [10:0] f(input int line);
    return 11'((line * 'h1C3 + 'h230) & 'h7FF);
  endfunction

  function automatic vec_t mk(input bit w, input int a, input int d, input int er, input bit eh,
                              input int nm);
    vec_t v;
    v.w = w; v.a = 11'(a); v.d = 11'(d); v.er = 11'(er); v.eh = eh; v.nm = nm;
    return v;
  endfunction

  function automatic txn_t tx(input bit w, input int a, input int d);
    txn_t t;
    t.w = w; t.a = 11'(a); t.d = 11'(d);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Backing memory: accepts when enabled, returns fill data 3 cycles after handshake.
  initial begin
    int pend;
    logic [10:0] pdata;
    pend = 0;
    pdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = f(i);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      bus.mem_req_ready  = mem_ready_en;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = pdata;
          end
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          mlog.push_back(tx(bus.mem_req_write, int'(bus.mem_req_addr), int'(bus.mem_req_wdata)));
          if (bus.mem_req_write) begin
            mem[bus.mem_req_addr[10:4]] = bus.mem_req_wdata;
          end else begin
            pdata = mem[bus.mem_req_addr[10:4]];
            pend  = 3;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard and checks data, hit flag and statistics.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'(bus.resp_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          if (e.hit) exp_hits = (exp_hits == SMAX) ? SMAX : exp_hits + 1;
          else exp_misses = (exp_misses == SMAX) ? SMAX : exp_misses + 1;
          chk("resp_rdata", 32'(bus.resp_rdata), 32'(e.rd));
          chk("resp_hit", 32'(bus.resp_hit), 32'(e.hit));
          chk("hit_count", 32'(hit_count), 32'(exp_hits));
          chk("miss_count", 32'(miss_count), 32'(exp_misses));
        end
      end
    end
  end

  task automatic issue_req(input bit w, input logic [10:0] a, input logic [10:0] d,
                           input logic [10:0] er, input bit eh);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 32'(bus.req_ready), 32'(1));
    end else begin
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      e.rd = er;
      e.hit = eh;
      sb.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'(sb.size()), 32'(0));
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'(1));
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'(0));
    chk({tag, "_resp_rdata"}, 32'(bus.resp_rdata), 32'(0));
    chk({tag, "_resp_hit"}, 32'(bus.resp_hit), 32'(0));
    chk({tag, "_mem_valid"}, 32'(bus.mem_req_valid), 32'(0));
    chk({tag, "_mem_write"}, 32'(bus.mem_req_write), 32'(0));
    chk({tag, "_mem_addr"}, 32'(bus.mem_req_addr), 32'(0));
    chk({tag, "_mem_wdata"}, 32'(bus.mem_req_wdata), 32'(0));
    chk({tag, "_hits"}, 32'(hit_count), 32'(0));
    chk({tag, "_misses"}, 32'(miss_count), 32'(0));
  endtask

  initial begin
    int n0, n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    tbl[0]  = mk(0, 'h013, 0, 'h3F3, 0, 1);
    tbl[1]  = mk(0, 'h01F, 0, 'h3F3, 1, 0);
    tbl[2]  = mk(0, 'h000, 0, f(0), 0, 1);
    tbl[3]  = mk(0, 'h040, 0, f(4), 0, 1);
    tbl[4]  = mk(0, 'h080, 0, f(8), 0, 1);
    tbl[5]  = mk(0, 'h0C0, 0, f(12), 0, 1);
    tbl[6]  = mk(0, 'h000, 0, f(0), 1, 0);
    tbl[7]  = mk(0, 'h100, 0, f(16), 0, 1);
    tbl[8]  = mk(0, 'h040, 0, f(4), 0, 1);
    tbl[9]  = mk(1, 'h000, 'h155, 'h155, 1, 0);
    tbl[10] = mk(0, 'h040, 0, f(4), 1, 0);
    tbl[11] = mk(0, 'h080, 0, f(8), 0, 1);
    tbl[12] = mk(0, 'h0C0, 0, f(12), 0, 1);
    tbl[13] = mk(0, 'h100, 0, f(16), 0, 2);
    tbl[14] = mk(0, 'h000, 0, 'h155, 0, 1);
    tbl[15] = mk(1, 'h230, 'h2AA, 'h2AA, 0, 1);
    tbl[16] = mk(0, 'h23C, 0, 'h2AA, 1, 0);

    elog.push_back(tx(0, 'h010, 0));
    elog.push_back(tx(0, 'h000, 0));
    elog.push_back(tx(0, 'h040, 0));
    elog.push_back(tx(0, 'h080, 0));
    elog.push_back(tx(0, 'h0C0, 0));
    elog.push_back(tx(0, 'h100, 0));
    elog.push_back(tx(0, 'h040, 0));
    elog.push_back(tx(0, 'h080, 0));
    elog.push_back(tx(0, 'h0C0, 0));
    elog.push_back(tx(1, 'h000, 'h155));
    elog.push_back(tx(0, 'h100, 0));
    elog.push_back(tx(0, 'h000, 0));
    elog.push_back(tx(0, 'h230, 0));

    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      n0 = mlog.size();
      issue_req(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].eh);
      wait_resp();
      chk($sformatf("mem_txn_count_%0d", i), 32'(mlog.size() - n0), 32'(tbl[i].nm));
    end

    chk("mem_log_len", 32'(mlog.size()), 32'(elog.size()));
    for (int i = 0; i < elog.size() && i < mlog.size(); i++) begin
      chk($sformatf("mem_log_w_%0d", i), 32'(mlog[i].w), 32'(elog[i].w));
      chk($sformatf("mem_log_addr_%0d", i), 32'(mlog[i].a), 32'(elog[i].a));
      if (elog[i].w) chk($sformatf("mem_log_data_%0d", i), 32'(mlog[i].d), 32'(elog[i].d));
    end
    chk("table_hits", 32'(hit_count), 32'(5));
    chk("table_misses", 32'(miss_count), 32'(12));

    // Hit latency: response in the cycle after E1, ready again after E2.
    issue_req(0, 11'h01F, 11'h000, 11'h3F3, 1);
    chk("t_e0_ready", 32'(bus.req_ready), 32'(0));
    chk("t_e0_resp", 32'(bus.resp_valid), 32'(0));
    @(negedge clk);
    chk("t_e1_resp", 32'(bus.resp_valid), 32'(1));
    @(negedge clk);
    chk("t_e2_resp", 32'(bus.resp_valid), 32'(0));
    chk("t_e2_ready", 32'(bus.req_ready), 32'(1));
    wait_resp();

    // Stalled fill request, then reset while waiting for fill data.
    mem_ready_en = 1'b0;
    issue_req(0, 11'h420, 11'h000, f('h42), 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(bus.mem_req_valid), 32'(1));
      chk("stall_addr", 32'(bus.mem_req_addr), 32'h420);
      chk("stall_write", 32'(bus.mem_req_write), 32'(0));
      chk("stall_no_resp", 32'(bus.resp_valid), 32'(0));
      @(negedge clk);
    end
    mem_ready_en = 1'b1;
    n = 0;
    while (bus.mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fill_accept", 32'(bus.mem_req_valid), 32'(0));
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    exp_hits = 0;
    exp_misses = 0;
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue_req(0, 11'h420, 11'h000, f('h42), 0);
    wait_resp();
    chk("post_rst_misses", 32'(miss_count), 32'(1));

    // Saturation of the hit counter.
    for (int i = 0; i < SMAX + 45; i++) begin
      issue_req(0, 11'h420, 11'h000, f('h42), 1);
      wait_resp();
    end
    chk("hit_saturated", 32'(hit_count), 32'(SMAX));
    chk("miss_after_sat", 32'(miss_count), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
